// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI mode helpers, byte width and state encoding shared by SPI blocks
package spi_pkg;

    localparam int c_MODE_0 = 0;
    localparam int c_MODE_1 = 1;
    localparam int c_MODE_2 = 2;
    localparam int c_MODE_3 = 3;

    localparam int c_BITS_PER_BYTE = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    function automatic logic f_cpol(input int mode);
        return (mode == c_MODE_2) || (mode == c_MODE_3);
    endfunction

    function automatic logic f_cpha(input int mode);
        return (mode == c_MODE_1) || (mode == c_MODE_3);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse detection
module spi_sync_edge #(
    parameter int   c_STAGES    = 2,
    parameter logic c_RESET_VAL = 1'b0
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [c_STAGES-1:0] sync_q;
    logic                dly_q;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            sync_q <= {c_STAGES{c_RESET_VAL}};
            dly_q  <= c_RESET_VAL;
        end else begin
            sync_q <= {sync_q[c_STAGES-2:0], din};
            dly_q  <= sync_q[c_STAGES-1];
        end
    end

    assign rise = sync_q[c_STAGES-1] & ~dly_q;
    assign fall = ~sync_q[c_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI responder with one-byte TX holding register
module spi_slave
    import spi_pkg::*;
#(
    parameter int         c_SPI_MODE    = 3,
    parameter int         c_SYNC_STAGES = 2,
    parameter logic [7:0] c_IDLE_BYTE   = 8'hFF
) (
    input  logic       i_CLK,
    input  logic       i_RESET_n,
    input  logic [7:0] i_TX_BYTE,
    input  logic       i_TX_DV,
    output logic       o_TX_READY,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_BYTE,
    input  logic       i_SPI_CLK,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_OE
);

    localparam logic c_CPOL  = f_cpol(c_SPI_MODE);
    localparam logic c_CPHA  = f_cpha(c_SPI_MODE);
    localparam int   c_CNT_W = $clog2(c_BITS_PER_BYTE);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_BITS_PER_BYTE - 1);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    logic [c_SYNC_STAGES-1:0] mosi_sync_q;
    logic                     mosi_s;

    spi_state_t state_q;
    spi_state_t state_d;

    logic [c_CNT_W-1:0] bit_cnt_q;
    logic [7:0]         rx_shift_q;
    logic [7:0]         tx_shift_q;
    logic [7:0]         hold_q;
    logic               hold_full_q;

    logic leading_edge;
    logic trailing_edge;
    logic sample_edge;
    logic shift_edge;

    logic frame_start;
    logic frame_stop;
    logic do_sample;
    logic do_shift;
    logic do_load;
    logic [7:0] load_byte;
    logic [7:0] rx_next;

    // Idle SCLK level is CPOL, so the SCLK synchronizer resets there to avoid a phantom edge.
    spi_sync_edge #(
        .c_STAGES    (c_SYNC_STAGES),
        .c_RESET_VAL (c_CPOL)
    ) u_sclk_sync (
        .i_CLK     (i_CLK),
        .i_RESET_n (i_RESET_n),
        .din       (i_SPI_CLK),
        .rise      (sclk_rise),
        .fall      (sclk_fall)
    );

    spi_sync_edge #(
        .c_STAGES    (c_SYNC_STAGES),
        .c_RESET_VAL (1'b1)
    ) u_cs_sync (
        .i_CLK     (i_CLK),
        .i_RESET_n (i_RESET_n),
        .din       (i_SPI_CS_n),
        .rise      (cs_rise),
        .fall      (cs_fall)
    );

    // Same depth as the SCLK path so MOSI lines up with the detected sample edge.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[c_SYNC_STAGES-2:0], i_SPI_MOSI};
        end
    end

    assign mosi_s = mosi_sync_q[c_SYNC_STAGES-1];

    assign leading_edge  = c_CPOL ? sclk_fall : sclk_rise;
    assign trailing_edge = c_CPOL ? sclk_rise : sclk_fall;
    assign sample_edge   = c_CPHA ? trailing_edge : leading_edge;
    assign shift_edge    = c_CPHA ? leading_edge  : trailing_edge;

    assign load_byte = hold_full_q ? hold_q : c_IDLE_BYTE;
    assign rx_next   = {rx_shift_q[6:0], mosi_s};

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_stop  = 1'b0;
        do_sample   = 1'b0;
        do_shift    = 1'b0;
        do_load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                    do_load     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    frame_stop = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge;
                    do_load   = sample_edge && (bit_cnt_q == c_LAST_BIT);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A strobe coinciding with a load of an empty register lands here for the next byte.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (do_load && hold_full_q) begin
            hold_full_q <= 1'b0;
        end else if (i_TX_DV && !hold_full_q) begin
            hold_q      <= i_TX_BYTE;
            hold_full_q <= 1'b1;
        end
    end

    assign o_TX_READY = ~hold_full_q;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            o_RX_BYTE  <= '0;
            o_RX_DV    <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            if (frame_stop || frame_start) begin
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
            end else if (do_sample) begin
                rx_shift_q <= rx_next;
                bit_cnt_q  <= bit_cnt_q + c_CNT_W'(1);
                if (bit_cnt_q == c_LAST_BIT) begin
                    o_RX_BYTE <= rx_next;
                    o_RX_DV   <= 1'b1;
                end
            end
        end
    end

    // In CPHA=0 the MSB goes out at CS_n fall, so the shifter keeps only the remaining bits.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            tx_shift_q    <= '0;
            o_SPI_MISO    <= 1'b1;
            o_SPI_MISO_OE <= 1'b0;
        end else if (frame_stop) begin
            o_SPI_MISO    <= 1'b1;
            o_SPI_MISO_OE <= 1'b0;
        end else if (frame_start) begin
            o_SPI_MISO_OE <= 1'b1;
            if (!c_CPHA) begin
                o_SPI_MISO <= load_byte[7];
                tx_shift_q <= {load_byte[6:0], 1'b0};
            end else begin
                tx_shift_q <= load_byte;
            end
        end else if (do_load) begin
            tx_shift_q <= load_byte;
        end else if (do_shift) begin
            o_SPI_MISO <= tx_shift_q[7];
            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave in modes 3 and 0
module tb_spi_slave;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_byte;
    logic       tx_dv3, tx_dv0;
    logic       ready3, ready0;
    logic       rx_dv3, rx_dv0;
    logic [7:0] rx_byte3, rx_byte0;
    logic       sclk, mosi;
    logic       cs_n3, cs_n0;
    logic       miso3, miso0;
    logic       oe3, oe0;

    int  cur_mode;
    logic sel;
    logic ready_s, rxdv_s, miso_s, oe_s;
    logic [7:0] rxb_s;

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq3[$];
    logic [7:0] rxq0[$];

    always #10 clk = ~clk;

    spi_slave #(.c_SPI_MODE(3), .c_SYNC_STAGES(2), .c_IDLE_BYTE(8'hFF)) u_dut3 (
        .i_CLK(clk), .i_RESET_n(rst_n), .i_TX_BYTE(tx_byte), .i_TX_DV(tx_dv3),
        .o_TX_READY(ready3), .o_RX_DV(rx_dv3), .o_RX_BYTE(rx_byte3),
        .i_SPI_CLK(sclk), .i_SPI_CS_n(cs_n3), .i_SPI_MOSI(mosi),
        .o_SPI_MISO(miso3), .o_SPI_MISO_OE(oe3)
    );

    spi_slave #(.c_SPI_MODE(0), .c_SYNC_STAGES(2), .c_IDLE_BYTE(8'hFF)) u_dut0 (
        .i_CLK(clk), .i_RESET_n(rst_n), .i_TX_BYTE(tx_byte), .i_TX_DV(tx_dv0),
        .o_TX_READY(ready0), .o_RX_DV(rx_dv0), .o_RX_BYTE(rx_byte0),
        .i_SPI_CLK(sclk), .i_SPI_CS_n(cs_n0), .i_SPI_MOSI(mosi),
        .o_SPI_MISO(miso0), .o_SPI_MISO_OE(oe0)
    );

    assign sel     = (cur_mode == 0);
    assign ready_s = sel ? ready0   : ready3;
    assign rxdv_s  = sel ? rx_dv0   : rx_dv3;
    assign rxb_s   = sel ? rx_byte0 : rx_byte3;
    assign miso_s  = sel ? miso0    : miso3;
    assign oe_s    = sel ? oe0      : oe3;

    always @(negedge clk) begin
        if (rx_dv3) rxq3.push_back(rx_byte3);
        if (rx_dv0) rxq0.push_back(rx_byte0);
    end

    typedef struct {
        int         mode;
        bit         has_tx;
        logic [7:0] tx;
        logic [7:0] mosi_b;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cs(input logic v);
        if (sel) cs_n0 = v;
        else     cs_n3 = v;
    endtask

    task automatic strobe_tx(input logic [7:0] b);
        tx_byte = b;
        if (sel) tx_dv0 = 1'b1;
        else     tx_dv3 = 1'b1;
        tick(1);
        tx_dv0 = 1'b0;
        tx_dv3 = 1'b0;
    endtask

    task automatic go_mode(input int m);
        cur_mode = m;
        sclk = (m >= 2);
        tick(HALF);
    endtask

    task automatic clear_q();
        @(posedge clk);
        rxq3.delete();
        rxq0.delete();
        @(negedge clk);
    endtask

    function automatic int q_size();
        return sel ? rxq0.size() : rxq3.size();
    endfunction

    function automatic logic [7:0] q_pop();
        if (q_size() == 0) return 8'hxx;
        return sel ? rxq0.pop_front() : rxq3.pop_front();
    endfunction

    task automatic xfer_byte(input logic [7:0] tx_m, output logic [7:0] rx_m);
        logic cpol, cpha;
        cpol = (cur_mode >= 2);
        cpha = ((cur_mode % 2) == 1);
        for (int i = 7; i >= 0; i--) begin
            if (!cpha) begin
                mosi = tx_m[i];
                tick(HALF);
                sclk = ~cpol;
                rx_m[i] = miso_s;
                tick(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = tx_m[i];
                tick(HALF);
                rx_m[i] = miso_s;
                sclk = cpol;
                tick(HALF);
            end
        end
    endtask

    task automatic frame(input int nbytes, input logic [7:0] m0, input logic [7:0] m1,
                         output logic [7:0] r0, output logic [7:0] r1);
        set_cs(1'b0);
        tick(2 * HALF);
        xfer_byte(m0, r0);
        r1 = 8'h00;
        if (nbytes > 1) xfer_byte(m1, r1);
        tick(HALF);
        set_cs(1'b1);
        tick(2 * HALF);
    endtask

    logic [7:0] r0, r1;

    initial begin
        rst_n = 1'b0; tx_byte = 8'h00; tx_dv3 = 1'b0; tx_dv0 = 1'b0;
        sclk = 1'b1; mosi = 1'b0; cs_n3 = 1'b1; cs_n0 = 1'b1; cur_mode = 3;

        vecs[0] = '{3, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{3, 1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A};
        vecs[2] = '{0, 1'b1, 8'h96, 8'hC3, 8'h96, 8'hC3};
        vecs[3] = '{0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{3, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{0, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};

        tick(3);
        check("rst_ready3", ready3, 1); check("rst_rxdv3", rx_dv3, 0);
        check("rst_rxbyte3", rx_byte3, 0); check("rst_miso3", miso3, 1);
        check("rst_oe3", oe3, 0);
        rst_n = 1'b1;
        tick(4);
        check("post_rst_ready0", ready0, 1); check("post_rst_rxbyte0", rx_byte0, 0);
        check("post_rst_miso0", miso0, 1); check("post_rst_oe0", oe0, 0);

        for (int v = 0; v < 6; v++) begin
            go_mode(vecs[v].mode);
            clear_q();
            if (vecs[v].has_tx) begin
                strobe_tx(vecs[v].tx);
                check("vec_ready_after_dv", ready_s, 0);
            end
            set_cs(1'b0);
            tick(2 * HALF);
            check("vec_ready_after_load", ready_s, 1);
            check("vec_oe_active", oe_s, 1);
            xfer_byte(vecs[v].mosi_b, r0);
            tick(HALF);
            set_cs(1'b1);
            tick(2 * HALF);
            check("vec_miso_byte", r0, vecs[v].exp_miso);
            check("vec_rx_count", q_size(), 1);
            check("vec_rx_byte", q_pop(), vecs[v].exp_rx);
            check("vec_oe_idle", oe_s, 0);
            check("vec_miso_idle", miso_s, 1);
        end

        go_mode(0);
        clear_q();
        frame(2, 8'h81, 8'h7E, r0, r1);
        check("m0_two_miso0", r0, 8'hFF);
        check("m0_two_miso1", r1, 8'hFF);
        check("m0_two_count", q_size(), 2);
        check("m0_two_rx0", q_pop(), 8'h81);
        check("m0_two_rx1", q_pop(), 8'h7E);

        go_mode(3);
        clear_q();
        strobe_tx(8'h11);
        fork
            frame(2, 8'h0F, 8'hF0, r0, r1);
            begin
                tick(2 * HALF + 12);
                check("hold_ready_after_load", ready_s, 1);
                strobe_tx(8'h22);
                check("hold_ready_low", ready_s, 0);
                strobe_tx(8'h33);
                tick(2);
                check("hold_ready_still_low", ready_s, 0);
            end
        join
        check("hold_miso0", r0, 8'h11);
        check("hold_miso1", r1, 8'h22);
        check("hold_rx_count", q_size(), 2);
        check("hold_rx0", q_pop(), 8'h0F);
        check("hold_rx1", q_pop(), 8'hF0);
        check("hold_ready_end", ready_s, 1);

        clear_q();
        strobe_tx(8'h00);
        set_cs(1'b0);
        tick(2 * HALF);
        for (int e = 0; e < 5; e++) begin
            sclk = ~sclk;
            mosi = 1'b1;
            tick(HALF);
        end
        check("abort_miso_mid", miso_s, 0);
        check("abort_oe_mid", oe_s, 1);
        set_cs(1'b1);
        tick(2 * HALF);
        check("abort_no_dv", q_size(), 0);
        check("abort_oe", oe_s, 0);
        check("abort_miso", miso_s, 1);
        go_mode(3);
        frame(1, 8'hC3, 8'h00, r0, r1);
        check("abort_next_count", q_size(), 1);
        check("abort_next_rx", q_pop(), 8'hC3);
        check("abort_next_miso", r0, 8'hFF);

        clear_q();
        set_cs(1'b0);
        tick(2 * HALF);
        strobe_tx(8'h77);
        check("rstmid_ready_low", ready_s, 0);
        for (int e = 0; e < 3; e++) begin
            sclk = ~sclk;
            tick(HALF);
        end
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_ready", ready_s, 1);
        check("rstmid_rxdv", rxdv_s, 0);
        check("rstmid_rxbyte", rxb_s, 0);
        check("rstmid_miso", miso_s, 1);
        check("rstmid_oe", oe_s, 0);
        set_cs(1'b1);
        sclk = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        clear_q();
        frame(1, 8'h5A, 8'h00, r0, r1);
        check("rstmid_next_count", q_size(), 1);
        check("rstmid_next_rx", q_pop(), 8'h5A);
        check("rstmid_next_miso", r0, 8'hFF);

        clear_q();
        for (int e = 0; e < 16; e++) begin
            sclk = ~sclk;
            mosi = e[0];
            tick(2);
        end
        check("cs_high_no_dv", q_size(), 0);
        check("cs_high_oe", oe_s, 0);
        go_mode(3);
        strobe_tx(8'h3A);
        frame(1, 8'hE7, 8'h00, r0, r1);
        check("cs_high_next_count", q_size(), 1);
        check("cs_high_next_rx", q_pop(), 8'hE7);
        check("cs_high_next_miso", r0, 8'h3A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
